// File: rtl/seq_generator.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB-first,
// optionally repeating it back-to-back repeat_cnt extra times.
module seq_generator #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] PATTERN = 5'b10110,
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_pat,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             outp,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [WIDTH-1:0] pat;
  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] pass;

  logic [WIDTH-1:0] start_pat;
  logic [IW-1:0]    idx_m1;

  // A start with load_en transmits the freshly loaded pattern.
  assign start_pat = load_en ? load_pat : pat;
  assign idx_m1    = idx - IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pat   <= PATTERN;
      idx   <= '0;
      pass  <= '0;
      outp  <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          outp  <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            state <= SEND;
            pat   <= start_pat;
            idx   <= IW'(WIDTH - 1);
            pass  <= repeat_cnt;
            outp  <= start_pat[WIDTH-1];
            valid <= 1'b1;
            busy  <= 1'b1;
          end else if (load_en) begin
            pat <= load_pat;
          end
        end
        SEND: begin
          if (abort) begin
            state <= IDLE;
            outp  <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (idx != '0) begin
            idx  <= idx_m1;
            outp <= pat[idx_m1];
          end else if (pass != '0) begin
            pass <= pass - CNT_W'(1);
            idx  <= IW'(WIDTH - 1);
            outp <= pat[WIDTH-1];
          end else begin
            state <= IDLE;
            outp  <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: hand-computed bit streams,
// done/abort/reset timing and a small 10110 detector model.
module tb_seq_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       load_en;
  logic [4:0] load_pat;
  logic [3:0] repeat_cnt;
  logic       outp;
  logic       valid;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_generator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .load_en    (load_en),
    .load_pat   (load_pat),
    .repeat_cnt (repeat_cnt),
    .outp       (outp),
    .valid      (valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic kick(input logic [3:0] rc);
    start      = 1'b1;
    repeat_cnt = rc;
    step();
    start = 1'b0;
  endtask

  // Checks passes*5 bits of p, then the done cycle (no step after it).
  task automatic expect_stream(input string tag, input logic [4:0] p,
                               input int passes);
    for (int k = 0; k < passes; k++)
      for (int i = 4; i >= 0; i--) begin
        check({tag, "_bit"}, {valid, busy, outp}, {2'b11, p[i]});
        step();
      end
    check({tag, "_done"}, {done, valid, busy, outp}, 4'b1000);
  endtask

  initial begin
    logic [4:0] sh;
    int         hits;
    logic [4:0] def;

    def        = 5'b10110;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    load_en    = 1'b0;
    load_pat   = 5'b0;
    repeat_cnt = 4'd0;
    step();
    check("reset", {done, valid, busy, outp}, 4'b0000);
    rst = 1'b0;
    step();
    check("idle", {done, valid, busy, outp}, 4'b0000);

    // Single pass
    kick(4'd0);
    expect_stream("t1", def, 1);
    step();
    check("t1_done_clr", {done, valid, busy}, 3'b000);

    // Three passes through a detector model; repeat_cnt change ignored
    kick(4'd2);
    repeat_cnt = 4'd0;
    sh   = '0;
    hits = 0;
    for (int n = 1; n <= 15; n++) begin
      check("t2_vb", {valid, busy}, 2'b11);
      sh = {sh[3:0], outp};
      if (n >= 5 && sh == 5'b10110) hits++;
      check("t2_det", 32'(n >= 5 && sh == 5'b10110), 32'(n % 5 == 0));
      step();
    end
    check("t2_done", {done, valid, busy, outp}, 4'b1000);
    check("t2_hits", hits, 3);
    step();

    // Load a new pattern, reuse it, then reset restores the default
    load_en  = 1'b1;
    load_pat = 5'b00001;
    step();
    load_en  = 1'b0;
    load_pat = 5'b11111;
    kick(4'd0);
    expect_stream("t3a", 5'b00001, 1);
    step();
    kick(4'd0);
    expect_stream("t3b", 5'b00001, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    kick(4'd0);
    expect_stream("t3c", def, 1);
    step();

    // Start together with load: loaded pattern sent at once
    load_en  = 1'b1;
    load_pat = 5'b01101;
    kick(4'd0);
    load_en = 1'b0;
    expect_stream("t3d", 5'b01101, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Start/load ignored while busy, then abort at bit 7
    kick(4'd1);
    for (int n = 0; n < 7; n++) begin
      check("t4_bit", {valid, busy, outp}, {2'b11, def[4 - (n % 5)]});
      if (n == 2) begin
        start    = 1'b1;
        load_en  = 1'b1;
        load_pat = 5'b11111;
      end
      if (n == 6) abort = 1'b1;
      step();
      start   = 1'b0;
      load_en = 1'b0;
      abort   = 1'b0;
    end
    for (int n = 0; n < 3; n++) begin
      check("t4_abort", {done, valid, busy, outp}, 4'b0000);
      step();
    end
    kick(4'd0);
    expect_stream("t4_after", def, 1);
    step();

    // Abort coinciding with the final bit suppresses done
    kick(4'd0);
    for (int i = 4; i >= 0; i--) begin
      check("t4b_bit", {valid, busy, outp}, {2'b11, def[i]});
      if (i == 0) abort = 1'b1;
      step();
      abort = 1'b0;
    end
    check("t4b_last", {done, valid, busy, outp}, 4'b0000);
    step();
    check("t4b_idle", {done, valid, busy}, 3'b000);

    // Reset mid-transmission
    kick(4'd0);
    step();
    check("t5_bit2", {valid, busy, outp}, 3'b110);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst", {done, valid, busy, outp}, 4'b0000);
    step();
    check("t5_idle", {done, valid, busy}, 3'b000);
    kick(4'd0);
    expect_stream("t5_after", def, 1);
    step();

    // Start held high: 5 bits + one done cycle, repeatedly
    start      = 1'b1;
    repeat_cnt = 4'd0;
    step();
    for (int t = 0; t < 3; t++) begin
      expect_stream("t6", def, 1);
      step();
    end
    start = 1'b0;
    check("t6_restart", {valid, busy, outp}, 3'b111);
    for (int i = 0; i < 5; i++) step();
    check("t6_end", {done, valid, busy}, 3'b100);
    step();

    // Maximum repeat count: 16 passes, 80 bits
    kick(4'd15);
    repeat_cnt = 4'd2;
    expect_stream("t7", def, 16);
    step();
    check("t7_idle", {done, valid, busy}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
